uart_tx_shift: RTL
==================

// Module: uart_tx_shift
// PURPOSE
//  Soft UART transmitter. Serialises one byte per frame onto tx_line using a frame shift register:
//  start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
//  Transmit-side counterpart of the soft UART receiver, with the same default bit timing.
//  Sits between a byte producer (valid/ready handshake) and the serial pin.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk cycles per serial bit (>=2); 50 MHz / 9600 baud
//  PARITY_EN     0     1 = insert parity bit after data bit 7
//  PARITY_ODD    0     valid only when PARITY_EN=1; 0 = even parity, 1 = odd parity
//  STOP_BITS     1     number of stop bits; legal values are 1 and 2
// PORTS
//  clk      in   1  system clock, rising edge
//  rst_n    in   1  asynchronous reset, active-low
//  tx_data  in   8  byte to send; sampled only on the accept cycle
//  tx_valid in   1  producer has a byte
//  tx_ready out  1  transmitter idle; a byte is accepted when tx_valid && tx_ready
//  tx_line  out  1  serial output; idles high; driven from a register
//  tx_busy  out  1  high while a frame is on the line
//  tx_done  out  1  one-cycle pulse when the last stop bit completes
// BEHAVIOUR
//  Reset (async, rst_n=0): tx_line=1, tx_ready=1, tx_busy=0, tx_done=0, FSM=IDLE, counters=0.
//   Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE:
//   - tx_ready=1.
//   - On accept at cycle N: latch {parity, tx_data} into the shift register; baud_cnt=0; bit_cnt=0.
//   - tx_line=0 and tx_busy=1 from cycle N+1.
//  Each bit is held exactly CLKS_PER_BIT cycles.
//   - baud_cnt counts 0..CLKS_PER_BIT-1; the wrap cycle is the bit-end tick.
//  START: on tick -> DATA; tx_line = shift_reg[0].
//  DATA:
//   - On each tick, shift right by 1 and bit_cnt++.
//   - After the tick with bit_cnt==7 -> PARITY if PARITY_EN, else STOP.
//  PARITY: tx_line = ^data XOR PARITY_ODD, using the parity computed at accept time; on tick -> STOP.
//  STOP: tx_line=1 for STOP_BITS*CLKS_PER_BIT cycles, then -> IDLE.
//   - On the first IDLE cycle: tx_done=1, tx_ready=1, tx_busy=0.
//  Frame length: (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles, from tx_line falling to IDLE.
//  Back-to-back frames:
//   - tx_valid held high is accepted on the first IDLE cycle, the same cycle as tx_done.
//   - The next start bit begins one cycle later; inter-frame idle is exactly 1 cycle.
//  tx_valid while busy is not accepted and has no effect; the producer must hold tx_valid and tx_data.
//  tx_data changes after the accept cycle do not affect the frame in flight.
//  tx_line is glitch-free: it is a flop output and changes only on bit-end ticks or at frame start.
//  Illegal STOP_BITS values (not 1 or 2) are a elaboration-time error via a generate-time check.
// STRUCTURE
//  Shared header uart_defs.vh holds:
//   - FSM state encodings (IDLE, START, DATA, PARITY, STOP; 3-bit)
//   - UART_DATA_BITS=8
//   - default CLKS_PER_BIT=5208
//  The receiver shares this header.
//  Sub-module uart_baud_tick (param CLKS_PER_BIT; ports clk, rst_n, clear, tick):
//   - Counter clears on frame start; tick pulses on wrap.
//   - Reusable by the receiver.
//  Top level holds the FSM, the shift register, bit_cnt and the output registers.
// TESTING (bench uses CLKS_PER_BIT=4 unless noted)
//  1. Reset: rst_n=0 mid-frame (data bit 3) -> same cycle tx_line=1, tx_busy=0, tx_ready=1;
//     then idles high with no tx_done.
//  2. 8N1, send 0xA5: start, then 1,0,1,0,0,1,0,1, stop; each bit 4 cycles.
//     tx_done fires 40 cycles after tx_line falls.
//  3. Parity even (PARITY_EN=1): 0x07 gives parity bit 1.
//     With PARITY_ODD=1, 0x07 gives parity bit 0. Frame is 44 cycles.
//  4. STOP_BITS=2: 0xFF -> line high for 8 stop cycles; total 44 cycles.
//  5. Back-to-back: tx_valid held, 0x55 then 0x3C.
//     Second accepted in the tx_done cycle; 1 idle cycle between frames.
//     Loopback into the receiver decodes both bytes.
//  6. Busy/hold: change tx_data to 0x00 and pulse tx_valid mid-frame -> frame still carries
//     the original byte; no extra frame is sent.

Source files
------------

// File: rtl/uart_tx_shift_pkg.sv
// Shared soft-UART definitions: FSM state encoding, frame constants and the parity helper.
// The receiver imports the same package so both ends agree on timing and encoding.
package uart_tx_shift_pkg;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_CLKS_PER_BIT_DEF = 5208;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity makes the total count of ones even; odd flips it.
  function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                      input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_shift_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the wrap cycle.
// clear restarts the period so a new frame always begins with a full-length bit.
module uart_baud_tick
  import uart_tx_shift_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_shift.sv
// Soft UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A byte is accepted on tx_valid && tx_ready and serialised from a frame shift register.
module uart_tx_shift
  import uart_tx_shift_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx_line,
  output logic                      tx_busy,
  output logic                      tx_done
);

  localparam int         SHIFT_W   = UART_DATA_BITS + 1;
  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       PAR_EN    = (PARITY_EN != 0);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);

  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_shift: STOP_BITS must be 1 or 2, got %0d", STOP_BITS);
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_shift: CLKS_PER_BIT must be >= 2, got %0d", CLKS_PER_BIT);
  end

  uart_state_e        state;
  uart_state_e        state_nx;
  logic [SHIFT_W-1:0] shreg;
  logic [2:0]         bit_cnt;
  logic               tick;
  logic               accept;
  logic               frame_top;
  logic               line_nx;
  logic               done_nx;

  assign accept    = tx_valid && tx_ready;
  // Bit above the data byte: the parity bit, or a stop-level 1 when parity is off.
  assign frame_top = PAR_EN ? parity_bit(tx_data, PAR_ODD) : 1'b1;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_START;
      end
      ST_START: begin
        if (tick) state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (tick && (bit_cnt == LAST_DATA)) state_nx = PAR_EN ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (tick) state_nx = ST_STOP;
      end
      ST_STOP: begin
        if (tick && (bit_cnt == LAST_STOP)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Next value of the registered line; after bit 7, shreg[1] holds the parity or stop bit.
  always_comb begin
    line_nx = tx_line;
    done_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        line_nx = !accept;
      end
      ST_START: begin
        if (tick) line_nx = shreg[0];
      end
      ST_DATA: begin
        if (tick) line_nx = shreg[1];
      end
      ST_PARITY: begin
        if (tick) line_nx = 1'b1;
      end
      ST_STOP: begin
        line_nx = 1'b1;
        if (tick && (bit_cnt == LAST_STOP)) done_nx = 1'b1;
      end
      default: line_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_line  <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_line  <= line_nx;
      tx_ready <= (state_nx == ST_IDLE);
      tx_busy  <= (state_nx != ST_IDLE);
      tx_done  <= done_nx;
    end
  end

  // bit_cnt indexes data bits in DATA and stop bits in STOP; it wraps to 0 leaving DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
    end else if (accept) begin
      bit_cnt <= 3'd0;
    end else if (tick && ((state == ST_DATA) || (state == ST_STOP))) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= {frame_top, tx_data};
    end else if (tick && (state == ST_DATA)) begin
      shreg <= {1'b1, shreg[SHIFT_W-1:1]};
    end
  end

endmodule
